flash_read_ctrl: RTL and testbench

- SPI master that sequences the board flash (P25Q32U-compatible) for bulk reads.
- Accepts a read job (24-bit start address plus byte count), issues command 0x03 and the address, then streams received bytes out over a valid/ready interface.
- Used at boot to copy the firmware image from flash into RAM. In simulation it drives the flash emulator.

---
 rtl/flash_read_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_flash_read_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : flash_read_ctrl                                            |
// | Description : SPI master for bulk reads from a P25Q32U-class flash.      |
// |               Sends READ (0x03) plus a 24-bit address, then streams the  |
// |               received bytes out over a valid/ready interface.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module flash_read_ctrl #(
   parameter int LENGTH_BIT_WIDTH = 16,
   parameter int CS_HIGH_CYCLES   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [23:0]                 address,
   input  logic [LENGTH_BIT_WIDTH-1:0] length,
   output logic                        busy,
   output logic                        done,
   output logic [7:0]                  out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        flash_clk,
   output logic                        flash_mosi,
   output logic                        flash_cs_n,
   input  logic                        flash_miso
);

   localparam logic [7:0] c_read_cmd = 8'h03;
   localparam int c_cnt_w = (CS_HIGH_CYCLES < 1) ? 1 : $clog2(CS_HIGH_CYCLES + 1);
   localparam logic [c_cnt_w-1:0]          c_cs_reload = c_cnt_w'(CS_HIGH_CYCLES);
   localparam logic [c_cnt_w-1:0]          c_cnt_one   = c_cnt_w'(1);
   localparam logic [LENGTH_BIT_WIDTH-1:0] c_len_one   = LENGTH_BIT_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DESELECT = 3'd1,
      S_COMMAND  = 3'd2,
      S_ADDRESS  = 3'd3,
      S_DATA     = 3'd4,
      S_STALL    = 3'd5,
      S_FINISH   = 3'd6
   } state_t;

   state_t                      state_q,    state_d;
   logic [31:0]                 tx_q,       tx_d;        // command+address, MSB drives mosi
   logic [7:0]                  rx_q,       rx_d;        // incoming byte shift register
   logic [4:0]                  bit_cnt_q,  bit_cnt_d;
   logic [LENGTH_BIT_WIDTH-1:0] byte_rem_q, byte_rem_d;  // bytes still to receive
   logic [c_cnt_w-1:0]          cs_cnt_q,   cs_cnt_d;    // deselect cycles still owed
   logic                        busy_q,     busy_d;
   logic                        done_q,     done_d;
   logic [7:0]                  out_data_q, out_data_d;
   logic                        out_valid_q, out_valid_d;
   logic                        fclk_q,     fclk_d;
   logic                        cs_n_q,     cs_n_d;
   logic [7:0]                  w_rx_next;

   assign w_rx_next = {rx_q[6:0], flash_miso};

   // State and output registers; reset aborts any job and restarts the deselect window.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tx_q        <= '0;
         rx_q        <= '0;
         bit_cnt_q   <= '0;
         byte_rem_q  <= '0;
         cs_cnt_q    <= c_cs_reload;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         fclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_rem_q  <= byte_rem_d;
         cs_cnt_q    <= cs_cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         fclk_q      <= fclk_d;
         cs_n_q      <= cs_n_d;
      end
   end

   // Next-state logic: each bit is a low half (mosi set up) then a high half (miso sampled at its end).
   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      bit_cnt_d   = bit_cnt_q;
      byte_rem_d  = byte_rem_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q & ~out_ready;
      fclk_d      = fclk_q;
      cs_n_d      = cs_n_q;
      // The deselect counter only runs down while chip select is high.
      if (cs_n_q) begin
         cs_cnt_d = (cs_cnt_q != '0) ? cs_cnt_q - c_cnt_one : '0;
      end else begin
         cs_cnt_d = c_cs_reload;
      end

      case (state_q)
         S_IDLE: begin
            if (start && !busy_q && (cs_cnt_q == '0)) begin
               if (length == '0) begin
                  done_d = 1'b1;
               end else begin
                  tx_d       = {c_read_cmd, address};
                  byte_rem_d = length;
                  bit_cnt_d  = '0;
                  busy_d     = 1'b1;
                  cs_n_d     = 1'b0;
                  fclk_d     = 1'b0;
                  state_d    = S_COMMAND;
               end
            end
         end

         S_COMMAND, S_ADDRESS: begin
            if (!fclk_q) begin
               fclk_d = 1'b1;
            end else begin
               fclk_d    = 1'b0;
               tx_d      = {tx_q[30:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 5'd1;
               if ((state_q == S_COMMAND) && (bit_cnt_q == 5'd7)) begin
                  state_d = S_ADDRESS;
               end else if ((state_q == S_ADDRESS) && (bit_cnt_q == 5'd31)) begin
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (!fclk_q) begin
               fclk_d = 1'b1;
            end else begin
               fclk_d    = 1'b0;
               rx_d      = w_rx_next;
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q[2:0] == 3'd7) begin
                  byte_rem_d = byte_rem_q - c_len_one;
                  if (byte_rem_q == c_len_one) begin
                     cs_n_d = 1'b1;
                  end
                  if (!out_valid_q || out_ready) begin
                     out_data_d  = w_rx_next;
                     out_valid_d = 1'b1;
                     state_d     = (byte_rem_q == c_len_one) ? S_FINISH : S_DATA;
                  end else begin
                     // Holding register still occupied: park with flash_clk low.
                     state_d = S_STALL;
                  end
               end
            end
         end

         S_STALL: begin
            if (out_ready) begin
               out_data_d  = rx_q;
               out_valid_d = 1'b1;
               state_d     = (byte_rem_q == '0) ? S_FINISH : S_DATA;
            end
         end

         S_FINISH: begin
            if (out_valid_q && out_ready) begin
               done_d = 1'b1;
               if (cs_cnt_d == '0) begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DESELECT;
               end
            end
         end

         S_DESELECT: begin
            // busy is the acceptance gate, so it is held until the flash has been deselected long enough.
            if (cs_cnt_d == '0) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign flash_clk  = fclk_q;
   assign flash_mosi = tx_q[31];
   assign flash_cs_n = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_read_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_flash_read_ctrl                                         |
// | Description : Directed self-checking bench for flash_read_ctrl with a    |
// |               small SPI flash model preloaded with 00..FF.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_flash_read_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [23:0] address;
   logic [15:0] length;
   logic        busy;
   logic        done;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        flash_clk;
   logic        flash_mosi;
   logic        flash_cs_n;
   logic        flash_miso = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   flash_read_ctrl #(
      .LENGTH_BIT_WIDTH(16),
      .CS_HIGH_CYCLES  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .address   (address),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flash_clk (flash_clk),
      .flash_mosi(flash_mosi),
      .flash_cs_n(flash_cs_n),
      .flash_miso(flash_miso)
   );

   // Clock and cycle index
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Flash model: shifts in command/address on rising edges, shifts data out on falling edges.
   logic [7:0]  mem [256];
   int          fbit = 0;
   logic [31:0] fin = '0;
   logic [7:0]  last_cmd = '0;
   logic [23:0] last_addr = '0;
   int          rises = 0;
   int          d;
   logic [23:0] ba;
   logic [7:0]  fb;

   always @(posedge flash_clk) rises = rises + 1;

   always @(posedge flash_clk or posedge flash_cs_n) begin
      if (flash_cs_n) begin
         fbit = 0;
      end else begin
         if (fbit < 32) begin
            fin = {fin[30:0], flash_mosi};
            if (fbit == 31) begin
               last_cmd  = fin[31:24];
               last_addr = fin[23:0];
            end
         end
         fbit = fbit + 1;
      end
   end

   always @(negedge flash_clk) begin
      if (!flash_cs_n && fbit >= 32) begin
         d  = fbit - 32;
         ba = last_addr + 24'(d / 8);
         fb = mem[ba[7:0]];
         flash_miso = fb[3'(7 - (d % 8))];
      end
   end

   // Output monitor: handshakes, done pulses and chip-select activity, sampled mid-cycle.
   logic [7:0] got [$];
   int         got_cyc [$];
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         cs_falls = 0;
   int         hi_run = 0;
   int         last_hi_run = 0;
   logic       prev_cs = 1'b1;

   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         got.push_back(out_data);
         got_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (flash_cs_n === 1'b1) begin
         hi_run = hi_run + 1;
      end else begin
         if (prev_cs === 1'b1) begin
            cs_falls    = cs_falls + 1;
            last_hi_run = hi_run;
         end
         hi_run = 0;
      end
      prev_cs = flash_cs_n;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [23:0] a, input logic [15:0] l, output int t0);
      int k;
      address = a;
      length  = l;
      start   = 1'b1;
      k = 0;
      do begin
         step();
         k++;
      end while (busy !== 1'b1 && k < 200);
      start = 1'b0;
      t0 = cyc - 1;
      chk("accept", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done(input int dc0, input int lim);
      int k;
      k = 0;
      while (done_cnt == dc0 && k < lim) begin
         step();
         k++;
      end
      chk("done_seen", {31'd0, done_cnt != dc0}, 32'd1);
   endtask

   task automatic wait_idle(input int lim);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < lim) begin
         step();
         k++;
      end
      chk("busy_falls", {31'd0, busy}, 32'd0);
   endtask

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Directed sequence
   initial begin
      int t0, t0a, t0b, r0, r1, dc0, cf0, cb;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      rst = 1'b1; start = 1'b0; address = '0; length = '0; out_ready = 1'b1;
      repeat (3) step();
      chk("reset_values",
          {18'd0, busy, done, out_valid, out_data, flash_clk, flash_mosi, flash_cs_n},
          {18'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
      rst = 1'b0;

      // Idle after reset: nothing moves
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_quiet", {28'd0, flash_cs_n, flash_clk, busy, out_valid}, 32'h8);
      end

      // Four bytes from address 0, no backpressure
      got.delete(); got_cyc.delete();
      r0 = rises; dc0 = done_cnt;
      start_job(24'h000000, 16'd4, t0);
      wait_done(dc0, 400);
      chk("t2_nbytes", got.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got.size()) begin
            chk("t2_byte", {24'd0, got[i]}, i);
            chk("t2_valid_cycle", got_cyc[i] - t0, 81 + 16 * i);
         end
      end
      chk("t2_done_cycle", done_cyc - t0, 130);
      chk("t2_clk_rises", rises - r0, 64);
      chk("t2_cmd", {24'd0, last_cmd}, 32'h03);
      chk("t2_addr", {8'd0, last_addr}, 32'h0);
      wait_idle(50);

      // Three bytes with a 40-cycle consumer stall
      repeat (2) step();
      got.delete(); got_cyc.delete();
      out_ready = 1'b0;
      r0 = rises; dc0 = done_cnt;
      start_job(24'h000000, 16'd3, t0);
      for (int k = 0; k < 200 && out_valid !== 1'b1; k++) step();
      chk("t3_first_valid_cycle", cyc - t0, 81);
      r1 = rises;
      repeat (39) step();
      chk("t3_stall_rises", rises - r1, 8);
      chk("t3_stall_clk_low", {31'd0, flash_clk}, 32'd0);
      chk("t3_stall_cs_low", {31'd0, flash_cs_n}, 32'd0);
      step();
      out_ready = 1'b1;
      wait_done(dc0, 400);
      chk("t3_nbytes", got.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < got.size()) chk("t3_byte", {24'd0, got[i]}, i);
      end
      chk("t3_done_cycle", done_cyc - t0, 139);
      chk("t3_clk_rises", rises - r0, 56);
      wait_idle(50);

      // Zero-length job
      repeat (6) step();
      cf0 = cs_falls; dc0 = done_cnt;
      address = 24'h000123; length = 16'd0; start = 1'b1;
      step();
      chk("t4_done", {31'd0, done}, 32'd1);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      start = 1'b0;
      step();
      chk("t4_done_pulse", {31'd0, done}, 32'd0);
      repeat (5) step();
      chk("t4_no_cs", cs_falls - cf0, 0);
      chk("t4_done_count", done_cnt - dc0, 1);

      // Start held high across two jobs; mid-job pulses and input changes ignored
      got.delete(); got_cyc.delete();
      dc0 = done_cnt;
      start_job(24'h000010, 16'd1, t0a);
      start = 1'b1;
      address = 24'h000020; length = 16'd2;
      wait_done(dc0, 400);
      chk("t5_job1_nbytes", got.size(), 1);
      if (got.size() > 0) chk("t5_job1_byte", {24'd0, got[0]}, 32'h10);
      chk("t5_job1_addr", {8'd0, last_addr}, 32'h10);
      got.delete(); got_cyc.delete();
      dc0 = done_cnt;
      for (int k = 0; k < 50 && busy !== 1'b0; k++) step();
      cb = cyc;
      for (int k = 0; k < 50 && busy !== 1'b1; k++) step();
      t0b = cyc - 1;
      chk("t5_accept", {31'd0, busy}, 32'd1);
      start = 1'b0; address = 24'h000080; length = 16'd5;
      chk("t5_accept_after_busy_low", {31'd0, t0b >= cb}, 32'd1);
      step();
      chk("t5_cs_high_run", {31'd0, last_hi_run >= 4}, 32'd1);
      repeat (30) step();
      start = 1'b1;
      repeat (3) step();
      start = 1'b0;
      wait_done(dc0, 400);
      chk("t5_job2_nbytes", got.size(), 2);
      for (int i = 0; i < 2; i++) begin
         if (i < got.size()) chk("t5_job2_byte", {24'd0, got[i]}, 32'h20 + i);
      end
      chk("t5_job2_addr", {8'd0, last_addr}, 32'h20);
      cf0 = cs_falls;
      repeat (20) step();
      chk("t5_no_third_job", cs_falls - cf0, 0);
      chk("t5_idle_after", {31'd0, busy}, 32'd0);

      // Reset in the middle of the data phase, then a clean job
      got.delete(); got_cyc.delete();
      dc0 = done_cnt;
      start_job(24'h000000, 16'd8, t0);
      for (int k = 0; k < 200 && cyc < t0 + 113; k++) step();
      chk("t6_valid_before_rst", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      step();
      chk("t6_rst_cs", {31'd0, flash_cs_n}, 32'd1);
      chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      step();
      chk("t6_no_done", done_cnt - dc0, 0);
      got.delete(); got_cyc.delete();
      dc0 = done_cnt;
      start_job(24'h000040, 16'd2, t0);
      wait_done(dc0, 400);
      chk("t6_nbytes", got.size(), 2);
      for (int i = 0; i < 2; i++) begin
         if (i < got.size()) chk("t6_byte", {24'd0, got[i]}, 32'h40 + i);
      end
      chk("t6_addr", {8'd0, last_addr}, 32'h40);
      chk("t6_done_cycle", done_cyc - t0, 98);
      repeat (10) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
